// File: rtl/subtractor_16bit_serial.sv
// Multi-cycle subtractor: Z = X + ~Y + 1, processed one SLICE-bit slice per clock,
// least significant slice first, with flags matching the full-width adder.
module subtractor_16bit_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NSLICE - 1);

  logic [0:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] zr_q, zr_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             parity_q, parity_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [31:0]      sh;
  logic [SLICE-1:0] x_sl;
  logic [SLICE-1:0] y_sl;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] z_full;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    zr_d       = zr_q;
    c_d        = c_q;
    z_d        = z_q;
    sign_d     = sign_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    parity_d   = parity_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    sh         = 32'(idx_q) * 32'(SLICE);
    x_sl       = SLICE'(x_q >> sh);
    y_sl       = SLICE'(y_q >> sh);
    slice_sum  = {1'b0, x_sl} + {1'b0, ~y_sl} + (SLICE+1)'(c_q);
    // Merge the new slice into the partial result; on the last slice this is the full Z.
    z_full     = (zr_q & ~(SLICE_MASK << sh)) | (WIDTH'(slice_sum[SLICE-1:0]) << sh);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          x_d     = X;
          y_d     = Y;
          zr_d    = '0;
          c_d     = 1'b1;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        zr_d  = z_full;
        c_d   = slice_sum[SLICE];
        idx_d = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          idx_d      = '0;
          done_d     = 1'b1;
          z_d        = z_full;
          sign_d     = z_full[WIDTH-1];
          zero_d     = (z_full == '0);
          carry_d    = slice_sum[SLICE];
          parity_d   = ~^z_full;
          overflow_d = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) & (z_full[WIDTH-1] ^ x_q[WIDTH-1]);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      zr_q       <= '0;
      c_q        <= 1'b0;
      z_q        <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      parity_q   <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      zr_q       <= zr_d;
      c_q        <= c_d;
      z_q        <= z_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      parity_q   <= parity_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign Z        = z_q;
  assign sign     = sign_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign parity   = parity_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_subtractor_16bit_serial.sv
// Directed bench for subtractor_16bit_serial: vector table plus hand-written
// sequences for busy-start, back-to-back start, input changes and mid-run reset.
module tb_subtractor_16bit_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] X;
  logic [15:0] Y;
  logic        busy;
  logic        done;
  logic [15:0] Z;
  logic        sign;
  logic        zero;
  logic        carry;
  logic        parity;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        carry;
    logic        parity;
    logic        overflow;
  } vec_t;

  vec_t vecs[13];

  // Expected Z/flags currently held at the outputs (bench model, not read back).
  vec_t held;

  subtractor_16bit_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .Z(Z), .sign(sign), .zero(zero),
    .carry(carry), .parity(parity), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, " Z"},        32'(Z),        32'(e.z));
    check({tag, " sign"},     32'(sign),     32'(e.sign));
    check({tag, " zero"},     32'(zero),     32'(e.zero));
    check({tag, " carry"},    32'(carry),    32'(e.carry));
    check({tag, " parity"},   32'(parity),   32'(e.parity));
    check({tag, " overflow"}, 32'(overflow), 32'(e.overflow));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an operation (caller sits just after a rising edge) and follow it to done.
  task automatic run_op(input string tag, input vec_t v);
    X = v.x;
    Y = v.y;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n < 4) begin
        check({tag, " busy mid"}, 32'(busy), 32'd1);
        check({tag, " done early"}, 32'(done), 32'd0);
        check({tag, " Z held"}, 32'(Z), 32'(held.z));
      end else begin
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check_outputs(tag, v);
      end
    end
    held = v;
  endtask

  initial begin
    //            x         y         z        s     zr    c     p     ov
    vecs[0]  = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{16'h0F0F, 16'h0101, 16'h0E0E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{16'hABCD, 16'h1234, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    held  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst   = 1'b1;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_outputs("reset", held);

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
      tick();
      check($sformatf("vec%0d done one cycle", i), 32'(done), 32'd0);
      check_outputs($sformatf("vec%0d hold", i), held);
    end

    // Operands change right after capture: result must follow the captured values.
    X = 16'h1234;
    Y = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    X = 16'hFFFF;
    Y = 16'h0001;
    for (int n = 1; n <= 4; n++) tick();
    check("xy change done", 32'(done), 32'd1);
    check_outputs("xy change", vecs[4]);
    held = vecs[4];
    tick();

    // Start pulses while busy are ignored; start in the done cycle is accepted.
    X = 16'h0003;
    Y = 16'h0005;
    start = 1'b1;
    tick();
    X = 16'h0005;
    Y = 16'h0003;
    for (int n = 1; n <= 3; n++) begin
      tick();
      check("busy-start busy", 32'(busy), 32'd1);
      check("busy-start no done", 32'(done), 32'd0);
    end
    start = 1'b0;
    tick();
    check("busy-start done", 32'(done), 32'd1);
    check_outputs("busy-start", vecs[1]);
    held = vecs[1];
    X = 16'h0005;
    Y = 16'h0003;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b done drops", 32'(done), 32'd0);
    check("b2b busy", 32'(busy), 32'd1);
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n < 4) begin
        check("b2b busy mid", 32'(busy), 32'd1);
        check("b2b no early done", 32'(done), 32'd0);
        check("b2b Z held", 32'(Z), 32'(held.z));
      end
    end
    check("b2b done", 32'(done), 32'd1);
    check_outputs("b2b", vecs[0]);
    held = vecs[0];
    tick();

    // Reset in the middle of a run aborts with outputs cleared and no done.
    X = 16'h8000;
    Y = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    held = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check_outputs("abort", held);
    for (int n = 0; n < 6; n++) begin
      tick();
      check("abort no done", 32'(done), 32'd0);
      check("abort idle", 32'(busy), 32'd0);
    end

    // Reset with start both high: stays idle.
    X = 16'h0005;
    Y = 16'h0003;
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst+start busy", 32'(busy), 32'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      check("rst+start no done", 32'(done), 32'd0);
    end
    check_outputs("rst+start", held);

    // Normal operation still works after the aborted run.
    run_op("post-abort", vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
